// File: rtl/ternary_pkg.sv
// Shared defaults for the ternary TPU datapath (PE array, feeder, psum drain).
package ternary_pkg;

  localparam int TPU_COLS     = 4;
  localparam int TPU_ACC_BITS = 32;

endpackage : ternary_pkg

// File: rtl/tpu_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset and synchronous flush.
// A push into a full FIFO only succeeds when a pop happens on the same edge.
module tpu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign empty     = (count_q == {CW{1'b0}});
  assign full      = (count_q == DEPTH_C);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Pointer and occupancy next-state; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, cleared on reset so the head never shows stale X.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s && !clear) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule : tpu_sync_fifo

// File: rtl/tpu_psum_drain.sv
// South-edge psum collector: de-skews the bottom PE row into aligned vectors
// and buffers them in a FIFO behind a valid/ready port with a fill watermark.
module tpu_psum_drain
  import ternary_pkg::*;
#(
  parameter int COLS     = TPU_COLS,
  parameter int ACC_BITS = TPU_ACC_BITS,
  parameter int DEPTH    = 8,
  parameter int SLACK    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     col0_valid,
  input  logic [COLS*ACC_BITS-1:0] psum_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS*ACC_BITS-1:0] out_data,
  output logic                     drain_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] SLACK_C = CW'(SLACK);

  logic [COLS*ACC_BITS-1:0] wvec_s;
  logic                     aligned_s;
  logic                     push_s, pop_s;
  logic                     full_s, empty_s;
  logic                     overflow_q, overflow_d;

  // Column c waits COLS-1-c enabled edges so it lines up with the last column.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c < COLS - 1) begin : g_dly
      localparam int D = COLS - 1 - c;
      logic [ACC_BITS-1:0] dly_q [D];

      // Per-column delay line, frozen while the array is stalled.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) begin
            dly_q[k] <= {ACC_BITS{1'b0}};
          end
        end else if (enable) begin
          dly_q[0] <= psum_in[c*ACC_BITS +: ACC_BITS];
          for (int k = 1; k < D; k++) begin
            dly_q[k] <= dly_q[k-1];
          end
        end
      end

      assign wvec_s[c*ACC_BITS +: ACC_BITS] = dly_q[D-1];
    end else begin : g_live
      assign wvec_s[c*ACC_BITS +: ACC_BITS] = psum_in[c*ACC_BITS +: ACC_BITS];
    end
  end

  if (COLS > 1) begin : g_vld
    logic [COLS-2:0] vld_q, vld_d;

    // Valid tag travels alongside column 0 through the same number of stages.
    always_comb begin
      vld_d = vld_q;
      if (clear) begin
        vld_d = {(COLS-1){1'b0}};
      end else if (enable) begin
        vld_d[0] = col0_valid;
        for (int k = 1; k < COLS - 1; k++) begin
          vld_d[k] = vld_q[k-1];
        end
      end else begin
        vld_d = vld_q;
      end
    end

    // Valid stage registers.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= {(COLS-1){1'b0}};
      end else begin
        vld_q <= vld_d;
      end
    end

    assign aligned_s = vld_q[COLS-2];
  end else begin : g_novld
    assign aligned_s = col0_valid;
  end

  assign push_s = enable && aligned_s;
  assign pop_s  = out_valid && out_ready;

  tpu_sync_fifo #(
    .WIDTH (COLS*ACC_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wvec_s),
    .rdata (out_data),
    .full  (full_s),
    .empty (empty_s),
    .count (fifo_count)
  );

  assign out_valid   = !empty_s;
  assign drain_ready = ((DEPTH_C - fifo_count) >= SLACK_C);

  // Sticky drop flag: a push into a full FIFO with no pop to make room.
  always_comb begin
    overflow_d = overflow_q;
    if (clear) begin
      overflow_d = 1'b0;
    end else if (push_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Overflow register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

endmodule : tpu_psum_drain
